// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Address of the optionally hardwired-zero register.
  localparam int ZERO_ADDR  = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-bit scoreboard: tracks which registers await a producer,
// keeps a live population count and a sticky unclaimed-write flag.
module reg_file_sb_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we_eff,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic                     i_claim_en,
  input  logic [ADDR_W-1:0]        i_claim_addr,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]        o_rd_pending,
  output logic [ADDR_W:0]          o_pending_cnt,
  output logic                     o_err_unclaimed
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_after_clr;
  logic [NREGS-1:0] w_pending_next;
  logic [ADDR_W:0]  r_cnt;
  logic             r_err;
  logic             w_claim_eff;
  logic             w_inc;
  logic             w_dec;

  // Claims on the hardwired-zero register are dropped.
  assign w_claim_eff = i_claim_en && !((ZERO_REG != 0) && (i_claim_addr == ZADDR));

  // Write clear is applied first, then the claim, so a same-address claim wins.
  always_comb begin
    w_after_clr = r_pending;
    if (i_we_eff) w_after_clr[i_wr_addr] = 1'b0;
    w_pending_next = w_after_clr;
    if (w_claim_eff) w_pending_next[i_claim_addr] = 1'b1;
  end

  // Count moves only on genuine 0->1 and 1->0 transitions of a bit.
  assign w_inc = w_claim_eff && !r_pending[i_claim_addr];
  assign w_dec = i_we_eff && r_pending[i_wr_addr] &&
                 !(w_claim_eff && (i_claim_addr == i_wr_addr));

  // Pending vector, population count and sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_cnt     <= r_cnt + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
      if (i_we_eff && !r_pending[i_wr_addr]) r_err <= 1'b1;
    end
  end

  assign o_pending_cnt   = r_cnt;
  assign o_err_unclaimed = r_err;

  // Per-port lookup sees this cycle's write clear but not its claim:
  // the claimer is younger than any same-cycle reader.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
      logic [ADDR_W-1:0] w_addr;
      logic              r_rd_pending;
      assign w_addr = i_rd_addr[gi*ADDR_W +: ADDR_W];

      // Registered pending flag for this read port.
      always_ff @(posedge clk) begin
        if (reset)
          r_rd_pending <= 1'b0;
        else if ((ZERO_REG != 0) && (w_addr == ZADDR))
          r_rd_pending <= 1'b0;
        else
          r_rd_pending <= w_after_clr[w_addr];
      end

      assign o_rd_pending[gi] = r_rd_pending;
    end
  endgenerate

endmodule : reg_file_sb_scoreboard

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD registered read ports, one write port,
// write-first bypass and a pending scoreboard for hazard detection.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [ADDR_W:0]          pending_cnt,
  output logic                     err_unclaimed
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_we_eff;

  // A write to the hardwired-zero register has no effect anywhere.
  assign w_we_eff = we && !((ZERO_REG != 0) && (wr_addr == ZADDR));

  // Storage array; cleared on reset so no output can carry X afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) r_mem[k] <= '0;
    end else if (w_we_eff) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] r_data;
      assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

      // Registered read with write-first bypass of the same-cycle write.
      always_ff @(posedge clk) begin
        if (reset)
          r_data <= '0;
        else if ((ZERO_REG != 0) && (w_addr == ZADDR))
          r_data <= '0;
        else if (w_we_eff && (wr_addr == w_addr))
          r_data <= wr_data;
        else
          r_data <= r_mem[w_addr];
      end

      assign rd_data[gi*DATA_W +: DATA_W] = r_data;
    end
  endgenerate

  reg_file_sb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk             (clk),
    .reset           (reset),
    .i_we_eff        (w_we_eff),
    .i_wr_addr       (wr_addr),
    .i_claim_en      (claim_en),
    .i_claim_addr    (claim_addr),
    .i_rd_addr       (rd_addr),
    .o_rd_pending    (rd_pending),
    .o_pending_cnt   (pending_cnt),
    .o_err_unclaimed (err_unclaimed)
  );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic [5:0]  pending_cnt;
  logic        err_unclaimed;

  int n_pass  = 0;
  int n_total = 0;

  reg_file_sb dut (
    .clk           (clk),
    .reset         (reset),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_pending    (rd_pending),
    .we            (we),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .claim_en      (claim_en),
    .claim_addr    (claim_addr),
    .pending_cnt   (pending_cnt),
    .err_unclaimed (err_unclaimed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    we = 1'b0; claim_en = 1'b0; wr_addr = '0; wr_data = '0; claim_addr = '0;
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0;
    idle();
    step(); step();
    reset = 1'b0;
    $display("step: reset");
    chk("reset_rd_data", rd_data[31:0], 32'd0);
    chk("reset_rd_pending", 32'(rd_pending), 32'd0);
    chk("reset_cnt", 32'(pending_cnt), 32'd0);
    chk("reset_err", 32'(err_unclaimed), 32'd0);

    // Sweep every address on both ports after reset.
    $display("step: read sweep 0..31");
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      step();
      chk("sweep_data0", rd_data[31:0], 32'd0);
      chk("sweep_data1", rd_data[63:32], 32'd0);
      chk("sweep_pend", 32'(rd_pending), 32'd0);
    end
    chk("sweep_cnt", 32'(pending_cnt), 32'd0);

    // Claim r5: same-cycle reader must not see the claim.
    $display("step: claim r5");
    set_rd(5'd5, 5'd0);
    claim_en = 1'b1; claim_addr = 5'd5;
    step();
    chk("claim5_pend_same", 32'(rd_pending[0]), 32'd0);
    chk("claim5_cnt", 32'(pending_cnt), 32'd1);
    idle();
    step();
    chk("claim5_pend_next", 32'(rd_pending[0]), 32'd1);

    // Write r5 with bypass to port 0.
    $display("step: write r5=DEADBEEF");
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    chk("wr5_bypass", rd_data[31:0], 32'hDEADBEEF);
    chk("wr5_pend", 32'(rd_pending[0]), 32'd0);
    chk("wr5_cnt", 32'(pending_cnt), 32'd0);
    chk("wr5_err", 32'(err_unclaimed), 32'd0);
    idle();

    // Register 0 ignores both write and claim.
    $display("step: write+claim r0");
    set_rd(5'd0, 5'd0);
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    claim_en = 1'b1; claim_addr = 5'd0;
    step();
    chk("r0_data", rd_data[31:0], 32'd0);
    chk("r0_cnt", 32'(pending_cnt), 32'd0);
    chk("r0_err", 32'(err_unclaimed), 32'd0);
    idle();
    step();
    chk("r0_data_next", rd_data[31:0], 32'd0);
    chk("r0_pend_next", 32'(rd_pending[0]), 32'd0);

    // r7 pending, then write and claim r7 in the same cycle.
    $display("step: claim r7, then write+claim r7");
    claim_en = 1'b1; claim_addr = 5'd7;
    step();
    chk("claim7_cnt", 32'(pending_cnt), 32'd1);
    set_rd(5'd0, 5'd7);
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    claim_en = 1'b1; claim_addr = 5'd7;
    step();
    chk("wc7_bypass", rd_data[63:32], 32'h55);
    chk("wc7_pend_same", 32'(rd_pending[1]), 32'd0);
    chk("wc7_cnt", 32'(pending_cnt), 32'd1);
    idle();
    step();
    chk("wc7_pend_next", 32'(rd_pending[1]), 32'd1);
    chk("wc7_data_next", rd_data[63:32], 32'h55);
    chk("wc7_cnt_next", 32'(pending_cnt), 32'd1);
    chk("wc7_err", 32'(err_unclaimed), 32'd0);

    // Unclaimed write to r9 sets the sticky error but still writes.
    $display("step: unclaimed write r9=A5A5");
    set_rd(5'd9, 5'd5);
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5;
    step();
    chk("wr9_data", rd_data[31:0], 32'hA5A5);
    chk("wr9_err", 32'(err_unclaimed), 32'd1);
    chk("wr9_cnt", 32'(pending_cnt), 32'd1);
    chk("r5_stored", rd_data[63:32], 32'hDEADBEEF);
    idle();
    set_rd(5'd9, 5'd9);
    step(); step(); step();
    chk("r9_port0", rd_data[31:0], 32'hA5A5);
    chk("r9_port1", rd_data[63:32], 32'hA5A5);
    chk("err_sticky", 32'(err_unclaimed), 32'd1);

    // Claim r1..r15 (r7 already pending), then reset mid-sequence with a write.
    $display("step: claim r1..r15");
    for (int a = 1; a <= 15; a++) begin
      claim_en = 1'b1; claim_addr = 5'(a);
      step();
    end
    chk("cnt_15", 32'(pending_cnt), 32'd15);
    $display("step: reset mid-sequence with write r3");
    reset = 1'b1;
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF;
    claim_en = 1'b1; claim_addr = 5'd16;
    set_rd(5'd9, 5'd3);
    step();
    reset = 1'b0;
    idle();
    chk("mid_rst_cnt", 32'(pending_cnt), 32'd0);
    chk("mid_rst_err", 32'(err_unclaimed), 32'd0);
    chk("mid_rst_data0", rd_data[31:0], 32'd0);
    chk("mid_rst_pend", 32'(rd_pending), 32'd0);
    step();
    chk("post_rst_r9", rd_data[31:0], 32'd0);
    chk("post_rst_r3", rd_data[63:32], 32'd0);
    set_rd(5'd5, 5'd16);
    step();
    chk("post_rst_r5", rd_data[31:0], 32'd0);
    chk("post_rst_p16", 32'(rd_pending[1]), 32'd0);

    // Full claim sweep r1..r31, then re-claim and clears.
    $display("step: claim r1..r31");
    for (int a = 1; a <= 31; a++) begin
      claim_en = 1'b1; claim_addr = 5'(a);
      step();
    end
    chk("cnt_31", 32'(pending_cnt), 32'd31);
    claim_addr = 5'd3;
    step();
    chk("reclaim_cnt", 32'(pending_cnt), 32'd31);
    idle();
    $display("step: write r3 clears pending");
    set_rd(5'd3, 5'd31);
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    step();
    chk("clr3_cnt", 32'(pending_cnt), 32'd30);
    chk("clr3_pend0", 32'(rd_pending[0]), 32'd0);
    chk("p31_pend1", 32'(rd_pending[1]), 32'd1);
    $display("step: write r4 + claim r3");
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    claim_en = 1'b1; claim_addr = 5'd3;
    set_rd(5'd4, 5'd3);
    step();
    idle();
    chk("net0_cnt", 32'(pending_cnt), 32'd30);
    chk("net0_data", rd_data[31:0], 32'h44);
    step();
    chk("net0_p3", 32'(rd_pending[1]), 32'd1);
    chk("net0_p4", 32'(rd_pending[0]), 32'd0);
    chk("final_err", 32'(err_unclaimed), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file with N synchronous read ports, one write port, write-first bypass and a per-register pending scoreboard.
- Used by the pipelined datapath at decode: operands read in the same cycle as the writeback of an older instruction.
- The pending bits tell the hazard unit which sources are still awaiting a producer.
- Register 0 is optionally hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NREGS = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0; writes to it and claims on it are ignored

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
rd_pending  out  NUM_RD  registered pending flag for each read port's address
we  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
claim_en  in  1  mark claim_addr pending (issue of a producer)
claim_addr  in  ADDR_W  register being claimed
pending_cnt  out  ADDR_W+1  number of registers currently pending
err_unclaimed  out  1  sticky: a write hit a non-pending register

Behaviour:
- Reset is synchronous and active-high. On a clk edge with reset=1:
  - all NREGS registers <= 0; all pending bits <= 0
  - rd_data <= 0, rd_pending <= 0, pending_cnt <= 0, err_unclaimed <= 0
  - reset overrides we and claim_en in the same cycle.
- Read latency is 1 cycle. At each edge, for every port i: rd_data[i] <= value of rd_addr[i] as it stands after this cycle's write (write-first).
  - Bypass: if we=1 and wr_addr==rd_addr[i] and the write is effective, rd_data[i] <= wr_data.
  - Otherwise rd_data[i] <= stored value.
- Effective write: we=1 and not (ZERO_REG=1 and wr_addr==0). An ineffective write changes nothing.
- With ZERO_REG=1, reads of address 0 always return 0 and rd_pending=0.
- Read ports are independent; multiple ports on the same address return identical data.
- Pending bits are updated at each edge:
  - An effective write clears pending[wr_addr].
  - claim_en=1 sets pending[claim_addr]; a claim on address 0 is ignored when ZERO_REG=1.
  - Same address, write and claim in the same cycle: the claim wins, so the bit ends at 1.
- rd_pending[i] <= pending[rd_addr[i]] after applying this cycle's write clear but before this cycle's claim. The claiming instruction is younger than the reader in the same cycle.
- pending_cnt tracks the population of pending bits, updated per edge:
  - +1 when the claim sets a bit that was 0
  - −1 when the write clears a bit that was 1 and no same-address claim occurs
  - both in one cycle (different addresses) → net 0
  - range 0..NREGS−1 (NREGS with ZERO_REG=0); no wrap possible
- err_unclaimed is set when an effective write targets a register whose pending bit is 0. It is sticky until reset. The write still completes.
- Re-claiming an already pending register: no change; count does not increment.
- No X on outputs after the first reset edge.

Decomposition:
- Package reg_file_pkg holds:
  - default DATA_W/ADDR_W constants
  - typedef reg_addr_t (logic [ADDR_W-1:0])
  - typedef reg_data_t (logic [DATA_W-1:0])
  - localparam ZERO_ADDR
- Sub-module reg_file_sb_scoreboard owns:
  - the pending bit vector, pending_cnt and err_unclaimed
  - the write/claim priority logic and per-port pending lookup (NUM_RD lookups)
- The top level owns the storage array, bypass muxes and output registers.

Test Plan:
- Reset, then read all 32 addresses on both ports → rd_data=0 and rd_pending=0 one cycle after each address; pending_cnt=0.
- claim r5; next cycle write r5=0xDEADBEEF while rd_addr0=5 → same-edge rd_data0=0xDEADBEEF (bypass), rd_pending0=0, pending_cnt goes 1→0, err_unclaimed=0.
- Write r0=0x1234 and claim r0 (ZERO_REG=1) → read r0 returns 0, pending_cnt stays 0, err_unclaimed stays 0.
- claim r7 and write r7=0x55 in the same cycle with r7 previously pending → pending[7] stays 1, rd_pending for r7 next cycle =1, pending_cnt unchanged.
- Write r9=0xA5A5 with r9 never claimed → r9 reads 0xA5A5, err_unclaimed=1 and remains 1 until reset.
- Claim r1..r31 sequentially → pending_cnt=31. Assert reset mid-sequence with we=1 → all registers 0, pending_cnt=0, write discarded.
